mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 256x16 main memory between the core control FSM (port C) and a debug/loader master (port D). It sits between those masters and the memory instance. It sequences each access through a fixed request/grant/response protocol, so neither master needs to know the other exists. The memory has registered inputs and unregistered output: `q` is valid in the cycle after the edge that samples the address.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port 256x16 memory between the core control
//               FSM (port C) and a debug/loader master (port D). Every access
//               runs IDLE -> ACCESS [-> WAIT -> RESP] -> IDLE; all outputs are
//               registered. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie
//               breaking; otherwise port C has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                winner_q, winner_d;     // 1 = port D owns the access
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_wren_q, mem_wren_d;
    logic                c_gnt_q, c_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                c_rvalid_q, c_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                busy_q, busy_d;
    logic                d_wins;                 // arbitration result in IDLE

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_q, last_d;         // 1 = D won the previous arbitration

    // A tie goes to whichever port did not win last time.
    assign d_wins = d_req & (~c_req | ~last_q);
    assign last_d = (state_q == S_IDLE && (c_req || d_req)) ? d_wins : last_q;

    // Last-winner register; resets to D so C takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: D only wins when C is not asking.
    assign d_wins = d_req & ~c_req;
`endif

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        c_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (c_req || d_req) begin
                    state_d    = S_ACCESS;
                    winner_d   = d_wins;
                    mem_addr_d = d_wins ? d_addr  : c_addr;
                    mem_data_d = d_wins ? d_wdata : c_wdata;
                    mem_wren_d = d_wins ? d_we    : c_we;
                    c_gnt_d    = ~d_wins;
                    d_gnt_d    = d_wins;
                end
            end
            S_ACCESS: begin
                // mem_wren_q still carries the winner's write flag here.
                state_d = mem_wren_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                state_d = S_RESP;
                if (winner_q) begin
                    d_rdata_d  = mem_q;
                    d_rvalid_d = 1'b1;
                end else begin
                    c_rdata_d  = mem_q;
                    c_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            winner_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            c_gnt_q    <= c_gnt_d;
            d_gnt_q    <= d_gnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign c_gnt    = c_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a behavioural
//               256x16 memory (registered inputs, unregistered output).
//               Honours MEM_ARB_ROUND_ROBIN_EN for the tie expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [7:0]  c_addr, d_addr;
    logic [15:0] c_wdata, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [15:0] c_rdata, d_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .mem_q    (mem_q),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: preloaded on the first edge, then written on wren.
    logic [15:0] mem [0:255];
    logic [7:0]  maddr_q;
    logic        preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
            mem[8'h10] <= 16'hBEEF;
            mem[8'h30] <= 16'h7777;
            preloaded  <= 1'b1;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_data;
        end
        maddr_q <= mem_addr;
    end
    assign mem_q = mem[maddr_q];

    typedef struct {
        logic        port;   // 1 = D
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;    // expected read data (reads only)
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {2'b00, c_gnt, d_gnt, c_rvalid, d_rvalid, c_rdata, d_rdata,
                mem_addr, mem_data, mem_wren, busy};
    endfunction

    // One complete transaction from IDLE; returns at a falling edge in IDLE.
    task automatic do_access(input logic port, input logic we, input logic [7:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        @(negedge clk);
        check("gnt", {62'd0, c_gnt, d_gnt}, port ? 64'd1 : 64'd2);
        check("wren_in_gnt", {63'd0, mem_wren}, {63'd0, we});
        check("mem_addr", {56'd0, mem_addr}, {56'd0, addr});
        if (we) check("mem_data", {48'd0, mem_data}, {48'd0, wdata});
        check("busy_access", {63'd0, busy}, 64'd1);
        c_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        if (we) begin
            check("wr_done_idle", {61'd0, busy, mem_wren, c_gnt | d_gnt}, 64'd0);
            check("wr_committed", {48'd0, mem[addr]}, {48'd0, wdata});
        end else begin
            check("wait_state", {60'd0, busy, mem_wren, c_rvalid, d_rvalid}, 64'd8);
            @(negedge clk);
            check("rvalid", {62'd0, c_rvalid, d_rvalid}, port ? 64'd1 : 64'd2);
            check("rdata", {48'd0, port ? d_rdata : c_rdata}, {48'd0, exp});
            @(negedge clk);
            check("rd_done_idle", {61'd0, busy, c_rvalid, d_rvalid}, 64'd0);
        end
    endtask

    initial begin
        logic [3:0] order;
        int         ngnt;
        int         dgnt_seen;
        logic       c_hold, d_hold;

        vecs[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'hFFFF};

        rst = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
        #2;
        check("reset_outs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_outs", all_outs(), 64'd0);

        // Tie: both ports keep requesting reads for four grants.
        order = 4'b0000; ngnt = 0; dgnt_seen = 0; c_hold = 1'b0; d_hold = 1'b0;
        c_we = 1'b0; c_addr = 8'h10; d_we = 1'b0; d_addr = 8'h11;
        c_req = 1'b1; d_req = 1'b1;
        for (int cyc = 0; cyc < 40 && ngnt < 4; cyc++) begin
            @(negedge clk);
            if (c_gnt && d_gnt) check("double_gnt", 64'd1, 64'd0);
            if (d_gnt) dgnt_seen++;
            if (c_gnt || d_gnt) begin
                order = {order[2:0], d_gnt};
                ngnt++;
            end
            if (c_gnt) begin c_req = 1'b0; c_hold = 1'b1; end
            else if (c_hold) begin c_hold = 1'b0; c_req = 1'b1; end
            if (d_gnt) begin d_req = 1'b0; d_hold = 1'b1; end
            else if (d_hold) begin d_hold = 1'b0; d_req = 1'b1; end
        end
        c_req = 1'b0; d_req = 1'b0;
        check("tie_grant_count", 64'(ngnt), 64'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("tie_order_rr", {60'd0, order}, 64'b0101);
`else
        check("tie_order_fixed", {60'd0, order}, 64'b0000);
        check("tie_d_never_gnt", 64'(dgnt_seen), 64'd0);
`endif
        for (int cyc = 0; cyc < 10 && busy; cyc++) @(negedge clk);
        check("tie_drain_idle", {63'd0, busy}, 64'd0);
        @(negedge clk);

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Pending loser: D asks during C's grant cycle, served after C's RESP.
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        @(negedge clk);
        check("pl_c_gnt", {63'd0, c_gnt}, 64'd1);
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        @(negedge clk);
        check("pl_d_wait1", {63'd0, d_gnt}, 64'd0);
        @(negedge clk);
        check("pl_c_rvalid", {62'd0, c_rvalid, d_gnt}, 64'd2);
        check("pl_c_rdata", {48'd0, c_rdata}, 64'hBEEF);
        @(negedge clk);
        check("pl_idle_gap", {62'd0, busy, d_gnt}, 64'd0);
        @(negedge clk);
        check("pl_d_gnt", {62'd0, c_gnt, d_gnt}, 64'd1);
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pl_d_rvalid", {63'd0, d_rvalid}, 64'd1);
        check("pl_d_rdata", {48'd0, d_rdata}, 64'h1234);
        check("pl_c_rdata_kept", {48'd0, c_rdata}, 64'hBEEF);
        @(negedge clk);

        // Reset in the middle of a D write's ACCESS cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 16'h5555;
        @(negedge clk);
        check("rst_pre_wren", {62'd0, mem_wren, d_gnt}, 64'd3);
        #1 rst = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        check("rst_write_aborted", {48'd0, mem[8'h30]}, 64'h7777);
        check("rst_held_outs", all_outs(), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_outs", all_outs(), 64'd0);
        do_access(1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
